// File: rtl/wd_kicker.sv
// -----------------------------------------------------------------------------
// wd_kicker
//   Watchdog keepalive bus master. Every KICK_PERIOD watchdog ticks it borrows
//   the 68k bus (BUS_REQ/BUS_GNT) and issues one byte write cycle (nLDS, RW=0)
//   to KICK_ADDR, which restarts the system watchdog. Kicks that are not
//   acknowledged within DTACK_TIMEOUT cycles, or that lose the grant while the
//   strobes are low, are abandoned and counted in FAIL_CNT. While the watchdog
//   holds nRESET_IN low the block releases the bus and waits.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   EN                   1 = kicking enabled
//   TICK                 one-CLK pulse per watchdog clock period
//   nRESET_IN            watchdog reset output, low = system in reset
//   BUS_REQ / BUS_GNT    bus request to / grant from the arbiter
//   nDTACK               68k data acknowledge, active low
//   BUS_OE               1 = this block drives address, strobes and RW
//   M68K_ADDR[23:1]      KICK_ADDR while BUS_OE=1, else 0
//   nAS, nLDS, nUDS, RW  68k bus control (nUDS always 1)
//   KICK_DONE/KICK_FAIL  one-CLK pulses: kick acknowledged / abandoned
//   FAIL_CNT             abandoned kicks since reset, saturating at 255
// -----------------------------------------------------------------------------
module wd_kicker #(
  parameter int unsigned KICK_PERIOD   = 4,
  parameter logic [23:1] KICK_ADDR     = 23'h180000,
  parameter int unsigned DTACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        EN,
  input  logic        TICK,
  input  logic        nRESET_IN,
  output logic        BUS_REQ,
  input  logic        BUS_GNT,
  input  logic        nDTACK,
  output logic        BUS_OE,
  output logic [23:1] M68K_ADDR,
  output logic        nAS,
  output logic        nLDS,
  output logic        nUDS,
  output logic        RW,
  output logic        KICK_DONE,
  output logic        KICK_FAIL,
  output logic [7:0]  FAIL_CNT
);

  localparam int unsigned      TMO_W    = $clog2(DTACK_TIMEOUT + 1);
  localparam logic [2:0]       KP       = 3'(KICK_PERIOD);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DTACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_ADDR, S_STROBE, S_RELEASE, S_HOLDOFF
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_oe_q, bus_oe_d;
  logic [23:1]      addr_q, addr_d;
  logic             n_as_q, n_as_d;
  logic             n_lds_q, n_lds_d;
  logic             n_uds_q, n_uds_d;
  logic             rw_q, rw_d;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    fail_cnt_d = fail_cnt_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    // Tick counter saturates at KICK_PERIOD so a long grant wait yields one
    // immediate follow-up kick rather than a backlog.
    cnt_inc    = (TICK && (cnt_q != KP)) ? cnt_q + 3'd1 : cnt_q;
    cnt_d      = cnt_inc;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (EN) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!EN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == KP) begin
          state_d = S_REQ;
          // A tick coinciding with the request edge belongs to the next period.
          cnt_d   = TICK ? 3'd1 : 3'd0;
        end
      end
      S_REQ: begin
        if (!EN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (BUS_GNT) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_STROBE;
        tmo_d   = '0;
      end
      S_STROBE: begin
        if (!nDTACK) begin
          state_d = S_RELEASE;
          done_d  = 1'b1;
        end else if (!BUS_GNT || (tmo_q == TMO_LAST)) begin
          state_d = S_RELEASE;
          fail_d  = 1'b1;
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = EN ? S_WAIT : S_IDLE;
      end
      S_HOLDOFF: begin
        cnt_d = '0;
        if (nRESET_IN) state_d = EN ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Watchdog reset overrides everything decided above, including pulses.
    if (!nRESET_IN) begin
      state_d    = S_HOLDOFF;
      cnt_d      = '0;
      tmo_d      = '0;
      done_d     = 1'b0;
      fail_d     = 1'b0;
      fail_cnt_d = fail_cnt_q;
    end

    // Bus outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    bus_req_d = state_d inside {S_REQ, S_ADDR, S_STROBE, S_RELEASE};
    bus_oe_d  = state_d inside {S_ADDR, S_STROBE, S_RELEASE};
    addr_d    = bus_oe_d ? KICK_ADDR : '0;
    rw_d      = ~bus_oe_d;
    n_as_d    = (state_d != S_STROBE);
    n_lds_d   = (state_d != S_STROBE);
    n_uds_d   = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      fail_cnt_q <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_oe_q   <= 1'b0;
      addr_q     <= '0;
      n_as_q     <= 1'b1;
      n_lds_q    <= 1'b1;
      n_uds_q    <= 1'b1;
      rw_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      fail_cnt_q <= fail_cnt_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      bus_req_q  <= bus_req_d;
      bus_oe_q   <= bus_oe_d;
      addr_q     <= addr_d;
      n_as_q     <= n_as_d;
      n_lds_q    <= n_lds_d;
      n_uds_q    <= n_uds_d;
      rw_q       <= rw_d;
    end
  end

  assign BUS_REQ   = bus_req_q;
  assign BUS_OE    = bus_oe_q;
  assign M68K_ADDR = addr_q;
  assign nAS       = n_as_q;
  assign nLDS      = n_lds_q;
  assign nUDS      = n_uds_q;
  assign RW        = rw_q;
  assign KICK_DONE = done_q;
  assign KICK_FAIL = fail_q;
  assign FAIL_CNT  = fail_cnt_q;

endmodule

// File: tb/tb_wd_kicker.sv
// -----------------------------------------------------------------------------
// tb_wd_kicker
//   Self-checking bench for wd_kicker. Inputs are driven and outputs sampled
//   on the falling clock edge. The reference model tracks tick credit toward
//   the next kick, the expected bus phase sequence and the failed-kick count;
//   a small watchdog model exercises the keepalive end to end.
// -----------------------------------------------------------------------------
module tb_wd_kicker;

  localparam int          KP    = 4;
  localparam logic [23:1] KADDR = 23'h180000;
  localparam int          TMO   = 16;

  logic        CLK = 1'b0;
  logic        nRST, EN, TICK, nRESET_IN, BUS_GNT, nDTACK;
  logic        BUS_REQ, BUS_OE, nAS, nLDS, nUDS, RW, KICK_DONE, KICK_FAIL;
  logic [23:1] M68K_ADDR;
  logic [7:0]  FAIL_CNT;

  int errors  = 0;
  int checks  = 0;
  int credit  = 0;   // ticks counted toward the next kick, saturating at KP
  int fails_m = 0;   // expected FAIL_CNT

  wd_kicker #(
    .KICK_PERIOD  (KP),
    .KICK_ADDR    (KADDR),
    .DTACK_TIMEOUT(TMO)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .EN       (EN),
    .TICK     (TICK),
    .nRESET_IN(nRESET_IN),
    .BUS_REQ  (BUS_REQ),
    .BUS_GNT  (BUS_GNT),
    .nDTACK   (nDTACK),
    .BUS_OE   (BUS_OE),
    .M68K_ADDR(M68K_ADDR),
    .nAS      (nAS),
    .nLDS     (nLDS),
    .nUDS     (nUDS),
    .RW       (RW),
    .KICK_DONE(KICK_DONE),
    .KICK_FAIL(KICK_FAIL),
    .FAIL_CNT (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic tk);
    TICK = tk;
    @(posedge CLK);
    @(negedge CLK);
    TICK = 1'b0;
  endtask

  function automatic void add_tick(input logic tk);
    if (tk && credit < KP) credit++;
  endfunction

  function automatic logic rtick(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic check_idle_bus(input string tag);
    check({tag, "_oe"},   BUS_OE,    1'b0);
    check({tag, "_addr"}, M68K_ADDR, '0);
    check({tag, "_as"},   nAS,       1'b1);
    check({tag, "_lds"},  nLDS,      1'b1);
    check({tag, "_uds"},  nUDS,      1'b1);
    check({tag, "_rw"},   RW,        1'b1);
  endtask

  // Step until a bus request is expected; BUS_REQ must rise exactly one cycle
  // after the tick credit reaches KP.
  task automatic wait_req(input int pct);
    logic tk, exp;
    int   n = 0;
    do begin
      exp = (credit == KP);
      tk  = rtick(pct);
      step(tk);
      check("req_timing", BUS_REQ, exp);
      check("wait_oe", BUS_OE, 1'b0);
      if (exp) credit = 0;
      add_tick(tk);
      n++;
      if (n > 300) begin
        check("req_never_seen", 1'b0, 1'b1);
        break;
      end
    end while (!(exp || BUS_REQ === 1'b1));
  endtask

  // From REQ: withhold grant g cycles, then run the bus cycle. DTACK comes
  // after d+1 strobe-low cycles; gl>0 drops grant at that strobe cycle;
  // rst_at>0 pulls nRESET_IN low at that strobe cycle; en_drop clears EN
  // once strobes are low.
  task automatic finish_kick(input int g, input int d, input int gl,
                             input int rst_at, input bit en_drop, input int pct);
    logic tk;
    int   low, outcome;
    for (int i = 0; i < g; i++) begin
      tk = rtick(pct); step(tk); add_tick(tk);
      check("req_hold", BUS_REQ, 1'b1);
      check("oe_no_gnt", BUS_OE, 1'b0);
    end
    BUS_GNT = 1'b1;
    tk = rtick(pct); step(tk); add_tick(tk);
    check("addr_oe",   BUS_OE,    1'b1);
    check("addr_val",  M68K_ADDR, KADDR);
    check("addr_rw",   RW,        1'b0);
    check("addr_as",   nAS,       1'b1);
    check("addr_lds",  nLDS,      1'b1);
    if (en_drop) EN = 1'b0;
    tk = rtick(pct); step(tk); add_tick(tk);
    check("strobe_as",  nAS,  1'b0);
    check("strobe_lds", nLDS, 1'b0);
    check("strobe_uds", nUDS, 1'b1);
    check("strobe_rw",  RW,   1'b0);
    low = 1;
    outcome = 0;
    while (outcome == 0) begin
      if (rst_at != 0 && low == rst_at) begin
        nRESET_IN = 1'b0;
        step(rtick(pct));
        check("hold_req", BUS_REQ, 1'b0);
        check_idle_bus("hold");
        check("hold_done", KICK_DONE, 1'b0);
        check("hold_fail", KICK_FAIL, 1'b0);
        check("hold_failcnt", FAIL_CNT, fails_m);
        BUS_GNT = 1'b0;
        for (int i = 0; i < 5; i++) begin
          step(1'b1);
          check("hold_ignore_tick", BUS_REQ, 1'b0);
        end
        nRESET_IN = 1'b1;
        step(1'b0);
        check("hold_exit_req", BUS_REQ, 1'b0);
        credit = 0;
        return;
      end
      if (low == d + 1) nDTACK = 1'b0;
      if (low == gl) BUS_GNT = 1'b0;
      tk = rtick(pct); step(tk); add_tick(tk);
      if (low == d + 1) outcome = 1;
      else if (low == gl || low == TMO) outcome = 2;
      else begin
        check("strobe_low_hold", nAS, 1'b0);
        low++;
      end
    end
    if (outcome == 1) begin
      check("done_pulse", KICK_DONE, 1'b1);
      check("done_nofail", KICK_FAIL, 1'b0);
    end else begin
      if (fails_m < 255) fails_m++;
      check("fail_pulse", KICK_FAIL, 1'b1);
      check("fail_nodone", KICK_DONE, 1'b0);
    end
    check("fail_cnt", FAIL_CNT, fails_m);
    check("rel_as",   nAS,       1'b1);
    check("rel_lds",  nLDS,      1'b1);
    check("rel_oe",   BUS_OE,    1'b1);
    check("rel_rw",   RW,        1'b0);
    check("rel_addr", M68K_ADDR, KADDR);
    nDTACK  = 1'b1;
    BUS_GNT = 1'b0;
    tk = rtick(pct); step(tk); add_tick(tk);
    check("post_req", BUS_REQ, 1'b0);
    check_idle_bus("post");
    check("post_done", KICK_DONE, 1'b0);
    check("post_fail", KICK_FAIL, 1'b0);
    if (en_drop) credit = 0;
  endtask

  initial begin
    int d, gl, rst_at, r, wd_ticks, trips, n, slow;
    logic tk;

    nRST = 1'b0; EN = 1'b1; TICK = 1'b0; nRESET_IN = 1'b1;
    BUS_GNT = 1'b0; nDTACK = 1'b1;
    step(1'b0); step(1'b1);
    check("rst_req", BUS_REQ, 1'b0);
    check_idle_bus("rst");
    check("rst_done", KICK_DONE, 1'b0);
    check("rst_fail", KICK_FAIL, 1'b0);
    check("rst_failcnt", FAIL_CNT, 8'd0);
    nRST = 1'b1;
    step(1'b0);
    credit = 0;
    check("idle_to_wait_req", BUS_REQ, 1'b0);

    // Basic kicks, immediate grant, DTACK after two strobe cycles.
    for (int i = 0; i < 3; i++) begin
      wait_req(50);
      finish_kick(0, 1, 0, 0, 1'b0, 50);
    end
    // Grant withheld 20 cycles.
    wait_req(40);
    finish_kick(20, 0, 0, 0, 1'b0, 40);
    // DTACK never comes: timeout after 16 strobe cycles, FAIL_CNT=1.
    wait_req(60);
    finish_kick(0, 99, 0, 0, 1'b0, 30);
    // DTACK on the last allowed cycle still completes.
    wait_req(60);
    finish_kick(1, 15, 0, 0, 1'b0, 30);
    // Watchdog reset during strobe.
    wait_req(60);
    finish_kick(0, 5, 0, 3, 1'b0, 30);
    // EN cleared during strobe: cycle completes, then idle.
    wait_req(60);
    finish_kick(0, 2, 0, 0, 1'b1, 30);
    for (int i = 0; i < 40; i++) begin
      step(i[0]);
      check("en_off_no_req", BUS_REQ, 1'b0);
    end
    EN = 1'b1; step(1'b0); credit = 0;
    // EN falling in REQ drops BUS_REQ next cycle.
    wait_req(60);
    EN = 1'b0; step(1'b0);
    check("en_off_in_req", BUS_REQ, 1'b0);
    EN = 1'b1; step(1'b0); credit = 0;
    // EN falling in WAIT with partial credit.
    step(1'b1); step(1'b1);
    EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check("en_off_in_wait", BUS_REQ, 1'b0);
    end
    EN = 1'b1; step(1'b0); credit = 0;

    // Randomized kicks.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(9));
      d = int'($urandom_range(17)); gl = 0; rst_at = 0;
      if (r >= 6 && r < 8) begin
        d = 99; gl = int'($urandom_range(16, 1));
      end else if (r >= 8) begin
        rst_at = int'($urandom_range((d + 1 > TMO) ? TMO : d + 1, 1));
      end
      wait_req(int'($urandom_range(80, 20)));
      finish_kick(int'($urandom_range(4)), d, gl, rst_at, 1'b0,
                  int'($urandom_range(80, 20)));
    end

    // FAIL_CNT saturation.
    for (int i = 0; i < 300; i++) begin
      wait_req(100);
      finish_kick(0, 99, 0, 0, 1'b0, 100);
    end
    check("fail_cnt_sat", FAIL_CNT, 8'd255);

    // Keepalive against a watchdog that trips after 8 ticks without a kick.
    wd_ticks = 0; trips = 0; slow = 0;
    for (int c = 0; c < 3000; c++) begin
      tk = (c % 3 == 0);
      step(tk);
      if (tk) wd_ticks++;
      if (!nAS && !nLDS && !RW && BUS_OE && M68K_ADDR == KADDR && slow == 0) wd_ticks = 0;
      if (wd_ticks >= 8) trips++;
      slow      = nAS ? 0 : slow + 1;
      nDTACK    = (slow >= 2) ? 1'b0 : 1'b1;
      BUS_GNT   = BUS_REQ;
      nRESET_IN = (wd_ticks < 8);
    end
    check("wd_no_trip", trips, 0);
    n = 0;
    while (KICK_DONE !== 1'b1 && n < 100) begin
      tk = (n % 3 == 0);
      step(tk);
      if (tk) wd_ticks++;
      slow    = nAS ? 0 : slow + 1;
      nDTACK  = (slow >= 2) ? 1'b0 : 1'b1;
      BUS_GNT = BUS_REQ;
      n++;
    end
    check("wd_kick_seen", KICK_DONE, 1'b1);
    EN = 1'b0; nDTACK = 1'b1; BUS_GNT = 1'b0;
    wd_ticks = 0; n = 0;
    for (int c = 0; c < 200 && wd_ticks < 8; c++) begin
      tk = (c % 3 == 0);
      step(tk);
      if (tk) begin wd_ticks++; n++; end
      if (!nAS && !nLDS && !RW && BUS_OE) wd_ticks = 0;
    end
    check("wd_trips_after_en_off", (wd_ticks >= 8) && (n <= 8), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
